result_collector: RTL

RESULT_COLLECTOR -- requirements
Module: result_collector

---
 rtl/result_collector.sv | 127 ++++++++++++
 1 files changed

// File: rtl/result_collector.sv
// result_collector: show-ahead FIFO collecting {flags, result} bytes from a
// processor for a host. Tracks occupancy, a sticky overflow flag for entries
// dropped while full, and an optional accepted-entry counter enabled by the
// macro RESULT_COLLECTOR_STATS_EN (total reads 0 when the macro is undefined).
module result_collector #(
    parameter int DEPTH = 16,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    input  logic [7:0]    result,
    input  logic [7:0]    flags,
    output logic          in_ready,
    input  logic          clear,
    output logic          out_valid,
    output logic [15:0]   out_data,
    input  logic          out_ready,
    output logic [CW-1:0] count,
    output logic          overflow,
    output logic [15:0]   total
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        PARTIAL = 2'd1,
        FULL    = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            overflow_q, overflow_d;
    logic [15:0]     mem_q [DEPTH];
    logic            push;
    logic            pop;

    // Handshake outputs derive from the registered state, so in_ready never
    // depends on out_ready in the same cycle.
    assign in_ready  = (state_q != FULL);
    assign out_valid = (state_q != EMPTY);
    assign out_data  = mem_q[rd_ptr_q];
    assign count     = count_q;
    assign overflow  = overflow_q;

    // Next-state, pointer, occupancy and overflow computation; clear wins.
    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        push       = in_valid && in_ready && !clear;
        pop        = out_valid && out_ready && !clear;

        if (clear) begin
            state_d    = EMPTY;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end else begin
            if (in_valid && !in_ready) overflow_d = 1'b1;
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            if (push && !pop) count_d = count_q + CW'(1);
            if (pop && !push) count_d = count_q - CW'(1);

            case (state_q)
                EMPTY:   if (push) state_d = PARTIAL;
                PARTIAL: begin
                    if (push && !pop && count_q == CW'(DEPTH - 1)) state_d = FULL;
                    if (pop && !push && count_q == CW'(1))         state_d = EMPTY;
                end
                FULL:    if (pop) state_d = PARTIAL;
                default: state_d = EMPTY;
            endcase
        end
    end

    // Control state register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= EMPTY;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Entry storage; contents need no reset since out_valid gates them.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {flags, result};
    end

`ifdef RESULT_COLLECTOR_STATS_EN
    logic [15:0] total_q, total_d;

    // Saturating count of accepted pushes; dropped entries are not counted.
    always_comb begin
        total_d = total_q;
        if (clear)                           total_d = '0;
        else if (push && total_q != 16'hFFFF) total_d = total_q + 16'd1;
    end

    // Accepted-entry counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) total_q <= '0;
        else        total_q <= total_d;
    end

    assign total = total_q;
`else
    assign total = '0;
`endif

endmodule
